// File: rtl/ps2_tx.sv
// -----------------------------------------------------------------------------
// ps2_tx -- host-to-device PS/2 transmitter (command byte to a keyboard).
//
// Sequence: request-to-send (hold clock low), start bit, 8 data bits LSB
// first, odd parity, stop bit (line released), then the device's ack bit.
// The device supplies every clock after the request-to-send phase. The PS/2
// clock is debounced by an 8-sample filter before its falling edges are used.
//
// Optional feature (macro PS2_TX_TIMEOUT_EN):
//   defined   - a watchdog aborts the transfer with tx_err=1 when the device
//               stops clocking for TIMEOUT_CYCLES clk cycles.
//   undefined - no watchdog; the block waits for device clocks indefinitely.
//
// Ports:
//   clk          in   system clock (only clock)
//   reset        in   synchronous, active-high reset
//   wr_ps2       in   one-cycle write strobe, honoured only while tx_idle=1
//   din[7:0]     in   command byte
//   ps2c_in      in   sampled PS/2 clock line
//   ps2d_in      in   sampled PS/2 data line
//   ps2c_oe      out  1 = pad pulls ps2c low, 0 = released
//   ps2d_oe      out  1 = pad pulls ps2d low, 0 = released
//   tx_idle      out  1 while idle (enables the companion receiver)
//   tx_done_tick out  one-cycle pulse at the end of every transfer
//   tx_err       out  result of the last transfer (1 = no ack / timeout)
// All outputs are registered.
// -----------------------------------------------------------------------------
module ps2_tx #(
    parameter int RTS_CYCLES     = 10000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int CW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RTS   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_ACK   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Odd parity bit: 1 when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [8:0]    r_shift;
    logic [8:0]    w_shift_next;
    logic [3:0]    r_nbit;
    logic [3:0]    w_nbit_next;
    logic          r_ack;
    logic          w_ack_next;

    logic [7:0]    r_filter;
    logic          r_fclk;
    logic          w_fclk_next;
    logic          w_fall;

    logic          r_ps2c_oe;
    logic          r_ps2d_oe;
    logic          r_tx_idle;
    logic          r_tx_done_tick;
    logic          r_tx_err;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WW-1:0] r_wdog;
    logic [WW-1:0] w_wdog_next;
`endif

    // Filtered clock: changes only after 8 identical samples, otherwise holds.
    always_comb begin
        w_fclk_next = r_fclk;
        if (r_filter == 8'hFF) begin
            w_fclk_next = 1'b1;
        end else if (r_filter == 8'h00) begin
            w_fclk_next = 1'b0;
        end else begin
            w_fclk_next = r_fclk;
        end
    end

    assign w_fall = r_fclk & ~w_fclk_next;

    // Clock filter shift register and filtered clock level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filter <= 8'hFF;
            r_fclk   <= 1'b1;
        end else begin
            r_filter <= {ps2c_in, r_filter[7:1]};
            r_fclk   <= w_fclk_next;
        end
    end

    // Next-state and datapath decode for the transfer sequence.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_nbit_next  = r_nbit;
        w_ack_next   = r_ack;
`ifdef PS2_TX_TIMEOUT_EN
        w_wdog_next  = r_wdog;
`endif
        case (r_state)
            S_IDLE: begin
                if (wr_ps2) begin
                    w_shift_next = {odd_parity(din), din};
                    w_cnt_next   = CW'(RTS_CYCLES - 1);
                    w_state_next = S_RTS;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RTS: begin
                if (r_cnt == '0) begin
                    w_state_next = S_START;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            S_START: begin
                if (w_fall) begin
                    w_nbit_next  = 4'd8;
                    w_state_next = S_DATA;
                end else begin
                    w_state_next = S_START;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    w_shift_next = {1'b0, r_shift[8:1]};
                    if (r_nbit == 4'd0) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_nbit_next = r_nbit - 4'd1;
                    end
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_ack_next   = ~ps2d_in;
                    w_state_next = S_ACK;
                end else begin
                    w_state_next = S_STOP;
                end
            end
            S_ACK: begin
                // Device must release both lines before the transfer closes.
                if (r_fclk && ps2d_in) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_ACK;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        // Watchdog: armed on entering start, re-armed by every device clock.
        // Expiry clears ack so the done state reports tx_err=1.
        if ((r_state == S_START) || (r_state == S_DATA) ||
            (r_state == S_STOP)  || (r_state == S_ACK)) begin
            if (r_wdog == '0) begin
                w_ack_next   = 1'b0;
                w_state_next = S_DONE;
            end else if (w_fall) begin
                w_wdog_next = WW'(TIMEOUT_CYCLES - 1);
            end else begin
                w_wdog_next = r_wdog - WW'(1);
            end
        end else if ((r_state == S_RTS) && (r_cnt == '0)) begin
            w_wdog_next = WW'(TIMEOUT_CYCLES - 1);
        end else begin
            w_wdog_next = r_wdog;
        end
`endif
    end

    // State, counters, shift register and ack capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= 9'd0;
            r_nbit  <= 4'd0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_nbit  <= w_nbit_next;
            r_ack   <= w_ack_next;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    // Device-inactivity watchdog counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_next;
        end
    end
`endif

    // Registered outputs decoded from the next state, so they line up
    // exactly with the state register and a reset releases the lines at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ps2c_oe      <= 1'b0;
            r_ps2d_oe      <= 1'b0;
            r_tx_idle      <= 1'b1;
            r_tx_done_tick <= 1'b0;
            r_tx_err       <= 1'b0;
        end else begin
            r_ps2c_oe      <= (w_state_next == S_RTS);
            r_ps2d_oe      <= (w_state_next == S_START) ||
                              ((w_state_next == S_DATA) && !w_shift_next[0]);
            r_tx_idle      <= (w_state_next == S_IDLE);
            r_tx_done_tick <= (w_state_next == S_DONE);
            r_tx_err       <= (w_state_next == S_DONE) ? ~w_ack_next : r_tx_err;
        end
    end

    assign ps2c_oe      = r_ps2c_oe;
    assign ps2d_oe      = r_ps2d_oe;
    assign tx_idle      = r_tx_idle;
    assign tx_done_tick = r_tx_done_tick;
    assign tx_err       = r_tx_err;

endmodule

// File: tb/tb_ps2_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_tx -- directed self-checking bench for ps2_tx
// (RTS_CYCLES=100, TIMEOUT_CYCLES=5000, device clock 400 cycles per bit).
// -----------------------------------------------------------------------------
module tb_ps2_tx;

    logic       clk;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;

    int n_checks;
    int n_errors;
    int n_done;

    // {stop, parity, d7..d0, start} as seen on the wire
    localparam logic [10:0] EXP_ED = 11'b11111011010;
    localparam logic [10:0] EXP_00 = 11'b11000000000;

    ps2_tx #(
        .RTS_CYCLES    (100),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c_in     (ps2c_in),
        .ps2d_in     (ps2d_in),
        .ps2c_oe     (ps2c_oe),
        .ps2d_oe     (ps2d_oe),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err      (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses
    always @(negedge clk) begin
        if (tx_done_tick) n_done <= n_done + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a write and measure how many sampled cycles ps2c_oe stays high.
    task automatic start_write(input logic [7:0] d, output int rts_len);
        din    = d;
        wr_ps2 = 1'b1;
        tick();
        wr_ps2 = 1'b0;
        rts_len = 0;
        while (ps2c_oe && rts_len < 1000) begin
            rts_len++;
            tick();
        end
    endtask

    // Device model: 11 clock pulses, 200 low / 200 high; samples the
    // open-drain data line at the end of each low phase.
    task automatic dev_xfer(input logic do_ack, input int glitch_p, input int wr_p,
                            output logic [10:0] seen);
        repeat (20) tick();
        seen    = 11'd0;
        seen[0] = ps2d_in & ~ps2d_oe;
        for (int p = 1; p <= 11; p++) begin
            ps2c_in = 1'b0;
            if (p == 11) ps2d_in = do_ack ? 1'b0 : 1'b1;
            repeat (199) tick();
            if (p <= 10) seen[p] = ps2d_in & ~ps2d_oe;
            tick();
            ps2c_in = 1'b1;
            ps2d_in = 1'b1;
            if (glitch_p == p) begin
                repeat (100) tick();
                ps2c_in = 1'b0;
                repeat (3) tick();
                ps2c_in = 1'b1;
                repeat (97) tick();
            end else if (wr_p == p) begin
                repeat (50) tick();
                din    = 8'hFF;
                wr_ps2 = 1'b1;
                tick();
                wr_ps2 = 1'b0;
                repeat (149) tick();
            end else begin
                repeat (200) tick();
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (ps2c_oe !== 1'b0) begin n_errors++; $display("FAIL reset_ps2c_oe got %b want 0", ps2c_oe); end
        n_checks++;
        if (ps2d_oe !== 1'b0) begin n_errors++; $display("FAIL reset_ps2d_oe got %b want 0", ps2d_oe); end
        n_checks++;
        if (tx_idle !== 1'b1) begin n_errors++; $display("FAIL reset_tx_idle got %b want 1", tx_idle); end
        n_checks++;
        if (tx_done_tick !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", tx_done_tick); end
        n_checks++;
        if (tx_err !== 1'b0) begin n_errors++; $display("FAIL reset_tx_err got %b want 0", tx_err); end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_ack_ed();
        int          len;
        int          base;
        logic [10:0] seen;
        base = n_done;
        din    = 8'hED;
        wr_ps2 = 1'b1;
        tick();
        wr_ps2 = 1'b0;
        n_checks++;
        if (tx_idle !== 1'b0) begin n_errors++; $display("FAIL rts_tx_idle got %b want 0", tx_idle); end
        len = 0;
        while (ps2c_oe && len < 1000) begin
            len++;
            tick();
        end
        n_checks++;
        if (len != 100) begin n_errors++; $display("FAIL rts_length got %0d want 100", len); end
        dev_xfer(1'b1, -1, -1, seen);
        n_checks++;
        if (seen !== EXP_ED) begin n_errors++; $display("FAIL ed_bits got %b want %b", seen, EXP_ED); end
        n_checks++;
        if (n_done - base != 1) begin n_errors++; $display("FAIL ed_done_count got %0d want 1", n_done - base); end
        n_checks++;
        if (tx_err !== 1'b0) begin n_errors++; $display("FAIL ed_tx_err got %b want 0", tx_err); end
        n_checks++;
        if (tx_idle !== 1'b1) begin n_errors++; $display("FAIL ed_tx_idle got %b want 1", tx_idle); end
    endtask

    task automatic test_nack();
        int          len;
        int          base;
        logic [10:0] seen;
        base = n_done;
        start_write(8'h00, len);
        dev_xfer(1'b0, -1, -1, seen);
        n_checks++;
        if (seen !== EXP_00) begin n_errors++; $display("FAIL nack_bits got %b want %b", seen, EXP_00); end
        n_checks++;
        if (n_done - base != 1) begin n_errors++; $display("FAIL nack_done_count got %0d want 1", n_done - base); end
        n_checks++;
        if (tx_err !== 1'b1) begin n_errors++; $display("FAIL nack_tx_err got %b want 1", tx_err); end
    endtask

    task automatic test_wr_ignored();
        int          len;
        int          base;
        logic [10:0] seen;
        base = n_done;
        start_write(8'hED, len);
        dev_xfer(1'b1, -1, 3, seen);
        n_checks++;
        if (seen !== EXP_ED) begin n_errors++; $display("FAIL wr_busy_bits got %b want %b", seen, EXP_ED); end
        n_checks++;
        if (n_done - base != 1) begin n_errors++; $display("FAIL wr_busy_done_count got %0d want 1", n_done - base); end
        n_checks++;
        if (tx_err !== 1'b0) begin n_errors++; $display("FAIL wr_busy_tx_err got %b want 0", tx_err); end
        repeat (200) tick();
        n_checks++;
        if (tx_idle !== 1'b1) begin n_errors++; $display("FAIL wr_busy_idle_after got %b want 1", tx_idle); end
    endtask

    task automatic test_glitch();
        int          len;
        int          base;
        logic [10:0] seen;
        base = n_done;
        start_write(8'hED, len);
        dev_xfer(1'b1, 5, -1, seen);
        n_checks++;
        if (seen !== EXP_ED) begin n_errors++; $display("FAIL glitch_bits got %b want %b", seen, EXP_ED); end
        n_checks++;
        if (n_done - base != 1) begin n_errors++; $display("FAIL glitch_done_count got %0d want 1", n_done - base); end
    endtask

    task automatic test_reset_rts();
        int base;
        din    = 8'hED;
        wr_ps2 = 1'b1;
        tick();
        wr_ps2 = 1'b0;
        repeat (49) tick();
        base  = n_done;
        reset = 1'b1;
        tick();
        n_checks++;
        if (ps2c_oe !== 1'b0) begin n_errors++; $display("FAIL rst_rts_ps2c_oe got %b want 0", ps2c_oe); end
        n_checks++;
        if (tx_idle !== 1'b1) begin n_errors++; $display("FAIL rst_rts_tx_idle got %b want 1", tx_idle); end
        reset = 1'b0;
        repeat (150) tick();
        n_checks++;
        if (n_done != base) begin n_errors++; $display("FAIL rst_rts_no_done got %0d want 0", n_done - base); end
        n_checks++;
        if (ps2c_oe !== 1'b0) begin n_errors++; $display("FAIL rst_rts_stays_released got %b want 0", ps2c_oe); end
    endtask

    task automatic test_timeout();
        int len;
        int base;
        int cnt;
        start_write(8'hED, len);
        base = n_done;
`ifdef PS2_TX_TIMEOUT_EN
        cnt = 0;
        while (!tx_done_tick && cnt < 6000) begin
            tick();
            cnt++;
        end
        n_checks++;
        if (cnt != 5000) begin n_errors++; $display("FAIL timeout_latency got %0d want 5000", cnt); end
        n_checks++;
        if (tx_err !== 1'b1) begin n_errors++; $display("FAIL timeout_tx_err got %b want 1", tx_err); end
        n_checks++;
        if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin
            n_errors++; $display("FAIL timeout_release got %b%b want 00", ps2c_oe, ps2d_oe);
        end
`else
        cnt = 0;
        repeat (6000) tick();
        n_checks++;
        if (ps2d_oe !== 1'b1) begin n_errors++; $display("FAIL no_wdog_ps2d_oe got %b want 1", ps2d_oe); end
        n_checks++;
        if (tx_idle !== 1'b0) begin n_errors++; $display("FAIL no_wdog_tx_idle got %b want 0", tx_idle); end
        n_checks++;
        if (n_done != base) begin n_errors++; $display("FAIL no_wdog_done got %0d want 0", n_done - base); end
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_done   = 0;
        reset    = 1'b1;
        wr_ps2   = 1'b0;
        din      = 8'h00;
        ps2c_in  = 1'b1;
        ps2d_in  = 1'b1;
        test_reset();
        test_ack_ed();
        test_nack();
        test_wr_ignored();
        test_glitch();
        test_reset_rts();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter RTS_CYCLES, default 10000; clk cycles ps2c is held low for request-to-send (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 200000; device-inactivity limit in clk cycles, used only under PS2_TX_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_ps2  input  1  one-cycle write strobe, honoured only when tx_idle=1.
REQ-006 SHALL have port din  input  8  command byte to the keyboard.
REQ-007 SHALL have port ps2c_in  input  1  sampled PS/2 clock line.
REQ-008 SHALL have port ps2d_in  input  1  sampled PS/2 data line.
REQ-009 SHALL have port ps2c_oe  output  1  1 = pad drives ps2c low; 0 = released.
REQ-010 SHALL have port ps2d_oe  output  1  1 = pad drives ps2d low; 0 = released.
REQ-011 SHALL have port tx_idle  output  1  1 in idle; drives ps2_rx rx_en.
REQ-012 SHALL have port tx_done_tick  output  1  one-cycle pulse at end of every transfer.
REQ-013 SHALL have port tx_err  output  1  result of last transfer (1 = no ack or timeout); valid from tx_done_tick until next transfer ends.

Function
REQ-014 SHALL filter ps2c_in with an 8-bit shift register: filtered clock goes 1 on all-ones and 0 on all-zeros, otherwise holds; fall_edge = filtered 1->0, one cycle.
REQ-015 SHALL implement states idle, rts, start, data, stop, ack, done.
REQ-016 idle: oe outputs 0, tx_idle=1; wr_ps2 latches {~^din, din} (odd parity) into a 9-bit shift register, loads the counter with RTS_CYCLES-1, and moves to rts.
REQ-017 rts: ps2c_oe=1; when counter reaches 0, move to start.
REQ-018 start: ps2c_oe=0, ps2d_oe=1 (start bit); on fall_edge load bit count 8 and move to data.
REQ-019 data: ps2d_oe = ~shift[0]; on fall_edge shift right; after 9 bits (d0..d7 LSB first, then parity) move to stop.
REQ-020 stop: both oe=0 (stop bit 1); on next fall_edge capture ack = ~ps2d_in and move to ack.
REQ-021 ack: wait until filtered clock=1 and ps2d_in=1, then move to done.
REQ-022 done: tx_done_tick=1 for exactly one cycle, tx_err = ~ack; next state idle.
REQ-023 wr_ps2 outside idle SHALL be ignored, with no effect on the latched byte.
REQ-024 fall_edge in idle or rts SHALL be ignored.
REQ-025 tx_idle SHALL be 0 in every state except idle.

Reset
REQ-026 reset SHALL force: state idle; ps2c_oe=0, ps2d_oe=0, tx_done_tick=0, tx_err=0, tx_idle=1; filter to all-ones; counters, shift register and ack to 0. A reset mid-transfer SHALL release both lines on the next clk edge.

Configuration
REQ-027 Macro PS2_TX_TIMEOUT_EN defined: a watchdog SHALL reload to TIMEOUT_CYCLES-1 on entering start and on each fall_edge. If it reaches 0 in start, data, stop or ack, the block SHALL release both lines, pulse tx_done_tick with tx_err=1, and return to idle.
REQ-028 Macro PS2_TX_TIMEOUT_EN undefined: no watchdog; the block waits indefinitely for device clocks.

Verification (RTS_CYCLES=100, TIMEOUT_CYCLES=5000, device model clock 400 cycles/bit)
REQ-029 wr_ps2 with din=8'hED, device acks -> ps2c_oe high exactly 100 cycles; data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done_tick single pulse; tx_err=0.
REQ-030 din=8'h00, device leaves ps2d high on the 11th edge -> parity bit 1; tx_done_tick pulse with tx_err=1.
REQ-031 wr_ps2 with din=8'hFF during data state of an 8'hED transfer -> transmitted bits unchanged (8'hED); one tx_done_tick only.
REQ-032 3-cycle low glitch on ps2c_in during data state -> no shift, no bit advance.
REQ-033 reset asserted during rts (cycle 50) -> next cycle ps2c_oe=0, tx_idle=1, no tx_done_tick.
REQ-034 Device never clocks. With PS2_TX_TIMEOUT_EN: tx_done_tick 5000 cycles after entering start, tx_err=1, both oe=0. Without the macro: block remains in start with ps2d_oe=1.
